axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 NUM_MASTERS, default 2, number of requesting masters (2..8).
REQ-002 ADDR_WIDTH, default axi_pkg::ADDR_WIDTH (32), address width.
REQ-003 DATA_WIDTH, default axi_pkg::DATA_WIDTH (32), data width; strobe width DATA_WIDTH/8.
REQ-004 ID_WIDTH, default axi_pkg::ID_WIDTH (4), master-side ID width; MIDX_W = axi_pkg::get_id_width(NUM_MASTERS).
REQ-005 ACLK  in  1  single clock; all state on rising edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 m_aw{valid,ready,addr,len,size,burst,id}  in/out  NUM_MASTERS x field width, packed by master index  per-master AW channel.
REQ-008 m_w{valid,ready,data,strb,last}  in/out  NUM_MASTERS x field width  per-master W channel.
REQ-009 m_b{valid,ready,resp,id}  out/in  NUM_MASTERS x field width  per-master B channel.
REQ-010 s_aw*, s_w*, s_b*  out/in  single-slave channels; s_awid/s_bid width ID_WIDTH+MIDX_W.
REQ-011 grant_idx  out  MIDX_W  currently granted master; busy  out  1  transaction in progress.
REQ-012 protocol_err  out  1  one-cycle pulse on WLAST/AWLEN mismatch.

Function
REQ-013 FSM states IDLE, ADDR_DATA, RESP; one write transaction outstanding at a time.
REQ-014 IDLE: when any m_awvalid set, select first requesting master searching from rr_ptr upward with wrap at NUM_MASTERS-1; register grant, go ADDR_DATA next cycle.
REQ-015 Grant latency: m_awvalid high at cycle N (IDLE) -> s_awvalid high at cycle N+1.
REQ-016 ADDR_DATA: s_aw* = granted master's AW fields; s_awid = {grant_idx, m_awid}; m_awready[g] = s_awready; all other m_awready = 0.
REQ-017 ADDR_DATA: W of granted master forwarded concurrently with AW (no W-after-AW dependency); s_wvalid = m_wvalid[g]; m_wready[g] = s_wready; others 0.
REQ-018 aw_done flag sets on s_aw handshake; s_awvalid deasserts once aw_done set.
REQ-019 Beat counter (8 bits) counts W handshakes; s_wlast driven from counter == latched AWLEN, not from master wlast.
REQ-020 W beats stall (s_wvalid = 0) when count > AWLEN would result; w_done sets on handshake with s_wlast = 1.
REQ-021 AW and W handshakes in same cycle both counted; transition to RESP when aw_done and w_done both set (including same cycle).
REQ-022 protocol_err pulses when W handshake has m_wlast != s_wlast; transaction continues on counter.
REQ-023 AWLEN not yet latched before aw_done: counter compares against m_awlen[g] directly (stable while AWVALID held).
REQ-024 RESP: m_bvalid[g] = s_bvalid, s_bready = m_bready[g], m_bresp[g] = s_bresp, m_bid[g] = s_bid[ID_WIDTH-1:0]; others 0.
REQ-025 On B handshake: rr_ptr <= grant_idx+1 (wrap to 0), flags and counter clear, go IDLE.
REQ-026 Non-granted m_awvalid held off indefinitely; no preemption; no starvation (round-robin).
REQ-027 busy = (state != IDLE).

Reset
REQ-028 ARESET high: state IDLE, rr_ptr 0, grant_idx 0, flags/counter 0, protocol_err 0, all valid/ready outputs 0, immediately (asynchronous).
REQ-029 Reset mid-transaction abandons it; no partial completion is signalled after release.

Structure
REQ-030 axi_pkg holds ADDR/DATA/ID width defaults, axi_resp_t, axi_burst_t, axi_size_t, get_id_width; the FSM state enum goes into axi_pkg as arb_state_t.
REQ-031 Round-robin priority selector is sub-module axi_rr_select (request vector, pointer -> one-hot/index, valid).
REQ-032 Channel muxing is combinational from registered grant; no extra pipeline registers.

Verification
REQ-033 M0 and M1 both awvalid at cycle 0, rr_ptr 0 -> M0 granted, s_awid = {0,m_awid}; after B, M1 granted; next simultaneous request -> M0.
REQ-034 AWLEN=0, AW and single W handshake same cycle -> s_wlast=1, RESP next cycle, B routed to M0 only.
REQ-035 AWLEN=3, W presented before s_awready (slave holds AWREADY until 2 beats accepted) -> no deadlock, 4 beats, AW accepted, B returned.
REQ-036 AWLEN=3, master asserts wlast on beat 2 -> protocol_err pulses once, s_wlast on beat 4 only.
REQ-037 ARESET asserted in ADDR_DATA after 2 beats -> outputs 0 same cycle, state IDLE, rr_ptr 0; fresh transaction completes normally.
REQ-038 s_bresp = SLVERR, s_bid = {1,4'hA} -> M1 receives bresp 2'b10, bid 4'hA; M0 bvalid stays 0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI widths, response/burst/size encodings and the write-arbiter FSM state type.
// get_id_width() gives the bits needed to tag a transaction with its master index.
package axi_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_RESP      = 2'd2
  } arb_state_t;

  // A single master still needs one index bit so the ID concatenation stays well-formed.
  function automatic int get_id_width(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_select.sv
// Round-robin priority selector: first asserted request at or above ptr, wrapping at N-1.
// Returns the winner both one-hot and as an index, plus a valid flag.
module axi_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N) sum -= N;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[wrap_add(ptr, i)]) begin
        valid                      = 1'b1;
        grant_idx                  = wrap_add(ptr, i);
        grant_oh[wrap_add(ptr, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// N-master to single-slave AXI write arbiter, one transaction outstanding, round-robin grant.
// AW and W of the granted master flow concurrently; WLAST toward the slave comes from a beat counter.
module axi_write_arbiter #(
  parameter int  NUM_MASTERS = 2,
  parameter int  ADDR_WIDTH  = axi_pkg::ADDR_WIDTH,
  parameter int  DATA_WIDTH  = axi_pkg::DATA_WIDTH,
  parameter int  ID_WIDTH    = axi_pkg::ID_WIDTH,
  localparam int MIDX_W      = axi_pkg::get_id_width(NUM_MASTERS),
  localparam int STRB_WIDTH  = DATA_WIDTH / 8,
  localparam int S_ID_WIDTH  = ID_WIDTH + MIDX_W
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_awid,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [NUM_MASTERS*2-1:0]          m_bresp,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]   m_bid,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic [7:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic [S_ID_WIDTH-1:0]             s_awid,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  output logic                              s_wlast,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  input  logic [1:0]                        s_bresp,
  input  logic [S_ID_WIDTH-1:0]             s_bid,
  output logic [MIDX_W-1:0]                 grant_idx,
  output logic                              busy,
  output logic                              protocol_err
);

  import axi_pkg::*;

  arb_state_t             state;
  logic [MIDX_W-1:0]      rr_ptr;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic                   aw_done;
  logic                   w_done;
  logic [7:0]             beat_cnt;
  logic [7:0]             awlen_q;

  logic [NUM_MASTERS-1:0] sel_oh;
  logic [MIDX_W-1:0]      sel_idx;
  logic                   sel_valid;

  axi_rr_select #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_rr_select (
    .req       (m_awvalid),
    .ptr       (rr_ptr),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx),
    .valid     (sel_valid)
  );

  logic [7:0]          g_awlen;
  logic [ID_WIDTH-1:0] g_awid;
  logic                g_awvalid, g_wvalid, g_wlast, g_bready;
  logic [7:0]          cur_len;
  logic                aw_fwd, w_fwd, b_fwd;
  logic                aw_hs, w_hs, b_hs;
  logic                aw_all, w_all;
  logic [MIDX_W-1:0]   next_ptr;
  logic                bid_route_unused;

  // Granted master's fields, selected straight from the registered grant.
  assign g_awlen   = m_awlen[grant_idx*8 +: 8];
  assign g_awid    = m_awid[grant_idx*ID_WIDTH +: ID_WIDTH];
  assign g_awvalid = m_awvalid[grant_idx];
  assign g_wvalid  = m_wvalid[grant_idx];
  assign g_wlast   = m_wlast[grant_idx];
  assign g_bready  = m_bready[grant_idx];

  // Before AW is accepted the master holds AWLEN stable, so it can be used directly.
  assign cur_len = aw_done ? awlen_q : g_awlen;
  assign aw_fwd  = (state == ST_ADDR_DATA) && !aw_done;
  assign w_fwd   = (state == ST_ADDR_DATA) && !w_done && (beat_cnt <= cur_len);
  assign b_fwd   = (state == ST_RESP);

  assign s_awvalid = aw_fwd & g_awvalid;
  assign s_awaddr  = m_awaddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_awlen   = g_awlen;
  assign s_awsize  = m_awsize[grant_idx*3 +: 3];
  assign s_awburst = m_awburst[grant_idx*2 +: 2];
  assign s_awid    = {grant_idx, g_awid};
  assign s_wvalid  = w_fwd & g_wvalid;
  assign s_wdata   = m_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign s_wstrb   = m_wstrb[grant_idx*STRB_WIDTH +: STRB_WIDTH];
  assign s_wlast   = (beat_cnt == cur_len);
  assign s_bready  = b_fwd & g_bready;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign b_hs   = s_bvalid & s_bready;
  assign aw_all = aw_done | aw_hs;
  assign w_all  = w_done | (w_hs & s_wlast);
  assign busy   = (state != ST_IDLE);

  assign next_ptr = (grant_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

  // The master-index bits of BID only steer routing; masters see their own ID.
  assign bid_route_unused = ^s_bid[S_ID_WIDTH-1:ID_WIDTH];

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_bid     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_oh[i]) begin
        m_awready[i] = aw_fwd & s_awready;
        m_wready[i]  = w_fwd & s_wready;
        m_bvalid[i]  = b_fwd & s_bvalid;
        if (b_fwd) begin
          m_bresp[i*2 +: 2]             = s_bresp;
          m_bid[i*ID_WIDTH +: ID_WIDTH] = s_bid[ID_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      grant_oh     <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      beat_cnt     <= '0;
      awlen_q      <= '0;
      protocol_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      protocol_err <= w_hs && (g_wlast != s_wlast);
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            grant_idx <= sel_idx;
            grant_oh  <= sel_oh;
            state     <= ST_ADDR_DATA;
          end
        end
        ST_ADDR_DATA: begin
          if (aw_hs) begin
            aw_done <= 1'b1;
            awlen_q <= g_awlen;
          end
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (s_wlast) w_done <= 1'b1;
          end
          if (aw_all && w_all) state <= ST_RESP;
        end
        ST_RESP: begin
          if (b_hs) begin
            rr_ptr   <= next_ptr;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with two masters: arbitration order, burst counting,
// early W, protocol error pulse, B routing and mid-transaction reset.
module tb_axi_write_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  m_awvalid, m_awready;
  logic [63:0] m_awaddr;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [3:0]  m_awburst;
  logic [7:0]  m_awid;
  logic [1:0]  m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wlast;
  logic [1:0]  m_bvalid, m_bready;
  logic [3:0]  m_bresp;
  logic [7:0]  m_bid;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic [4:0]  s_awid;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic [4:0]  s_bid;
  logic        grant_idx, busy, protocol_err;

  int passed = 0;
  int total  = 0;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .grant_idx(grant_idx), .busy(busy), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET    = 1'b1;
    m_awvalid = 2'b11;
    m_awaddr  = {32'h0000_2000, 32'h0000_1000};
    m_awlen   = {8'd0, 8'd0};
    m_awsize  = {3'd2, 3'd2};
    m_awburst = {2'b01, 2'b01};
    m_awid    = {4'hA, 4'h3};
    m_wvalid  = 2'b00;
    m_wdata   = {32'hBBBB_1111, 32'hAAAA_0000};
    m_wstrb   = 8'hFF;
    m_wlast   = 2'b00;
    m_bready  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    s_bid     = 5'h00;

    // Reset holds everything idle even with requests pending.
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_idx, 1'b0);
    check("rst_s_valid_ready", {s_awvalid, s_wvalid, s_bready, protocol_err}, 4'b0000);
    check("rst_m_valid_ready", {m_awready, m_wready, m_bvalid}, 6'b000000);
    step();
    check("rst_hold_busy", busy, 1'b0);

    // T1: simultaneous request, rr_ptr 0 -> M0; AWLEN 0 with AW and W in the same cycle.
    ARESET   = 1'b0;
    m_wvalid = 2'b11;
    m_wlast  = 2'b11;
    m_bready = 2'b11;
    #1;
    check("t1_cycle_n_awvalid", {busy, s_awvalid}, 2'b00);
    step();
    check("t1_grant", grant_idx, 1'b0);
    check("t1_busy_awvalid_wvalid", {busy, s_awvalid, s_wvalid}, 3'b111);
    check("t1_awid", s_awid, 5'h03);
    check("t1_awaddr", s_awaddr, 32'h0000_1000);
    check("t1_wdata", s_wdata, 32'hAAAA_0000);
    check("t1_wlast", s_wlast, 1'b1);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    #1;
    check("t1_m_awready", m_awready, 2'b01);
    check("t1_m_wready", m_wready, 2'b01);
    step();
    m_awvalid = 2'b10;
    m_wvalid  = 2'b10;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b1;
    s_bresp   = 2'b00;
    s_bid     = 5'h03;
    #1;
    check("t1_resp_state", {busy, s_awvalid, s_wvalid}, 3'b100);
    check("t1_m_bvalid", m_bvalid, 2'b01);
    check("t1_s_bready", s_bready, 1'b1);
    check("t1_m_bid", m_bid, 8'h03);
    check("t1_m_bresp", m_bresp, 4'b0000);
    check("t1_no_perr", protocol_err, 1'b0);
    step();
    s_bvalid = 1'b0;
    #1;
    check("t1_idle", {busy, m_bvalid}, 3'b000);

    // T2: M1 waited and is now granted; SLVERR returned to M1 only.
    step();
    check("t2_grant", grant_idx, 1'b1);
    check("t2_awid", s_awid, 5'h1A);
    check("t2_awaddr", s_awaddr, 32'h0000_2000);
    check("t2_wdata", s_wdata, 32'hBBBB_1111);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    #1;
    check("t2_m_ready", {m_awready, m_wready}, 4'b1010);
    step();
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b1;
    s_bresp   = axi_pkg::RESP_SLVERR;
    s_bid     = 5'h1A;
    #1;
    check("t2_m_bvalid", m_bvalid, 2'b10);
    check("t2_m_bresp", m_bresp, 4'b1000);
    check("t2_m_bid", m_bid, 8'hA0);
    step();
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    // T3 setup: both request, AWLEN 3, M0 offers W before the slave takes AW.
    m_awaddr  = {32'h0000_4000, 32'h0000_3000};
    m_awlen   = {8'd3, 8'd3};
    m_awid    = {4'h2, 4'h7};
    m_wlast   = 2'b00;
    m_awvalid = 2'b11;
    m_wvalid  = 2'b01;
    #1;
    check("t2_idle", busy, 1'b0);

    step();
    check("t3_grant_wrapped", grant_idx, 1'b0);
    check("t3_awid", s_awid, 5'h07);
    check("t3_awlen", s_awlen, 8'd3);
    check("t3_aw_w_valid", {s_awvalid, s_wvalid, s_wlast}, 3'b110);
    s_wready = 1'b1;
    step();
    step();
    s_awready = 1'b1;
    #1;
    check("t3_beat2_wlast", s_wlast, 1'b0);
    check("t3_late_awready", {m_awready, m_wready}, 4'b0101);
    step();
    s_awready = 1'b0;
    m_awvalid = 2'b10;
    m_wlast   = 2'b01;
    #1;
    check("t3_aw_done", {s_awvalid, m_awready}, 3'b000);
    check("t3_beat3_wlast", {busy, s_wvalid, s_wlast}, 3'b111);
    step();
    m_wvalid = 2'b00;
    m_wlast  = 2'b00;
    s_wready = 1'b0;
    s_bvalid = 1'b1;
    s_bid    = 5'h07;
    #1;
    check("t3_m_bvalid", m_bvalid, 2'b01);
    check("t3_m_bid", m_bid, 8'h07);
    check("t3_no_perr", protocol_err, 1'b0);
    step();
    s_bvalid = 1'b0;

    // T4: M1 granted, two beats accepted with AW stalled, then reset mid-burst.
    step();
    m_wvalid = 2'b10;
    s_wready = 1'b1;
    #1;
    check("t4_grant", grant_idx, 1'b1);
    check("t4_awid", s_awid, 5'h12);
    step();
    step();
    ARESET = 1'b1;
    #1;
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_grant", grant_idx, 1'b0);
    check("t4_rst_outputs", {s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid}, 8'h00);
    step();
    ARESET    = 1'b0;
    m_awvalid = 2'b11;
    m_wvalid  = 2'b00;
    s_wready  = 1'b0;
    m_awid    = {4'h2, 4'h9};
    #1;
    check("t4_release_quiet", {busy, s_awvalid, m_bvalid}, 4'b0000);

    // T5: rr_ptr back to 0 -> M0; master raises WLAST on beat 2 of 4.
    step();
    check("t5_grant_after_rst", grant_idx, 1'b0);
    check("t5_awid", s_awid, 5'h09);
    m_wvalid  = 2'b01;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    #1;
    check("t5_beat1_wlast", s_wlast, 1'b0);
    step();
    m_awvalid = 2'b10;
    m_wlast   = 2'b01;
    #1;
    check("t5_beat2_state", {protocol_err, s_wlast}, 2'b00);
    step();
    m_wlast = 2'b00;
    #1;
    check("t5_perr_pulse", protocol_err, 1'b1);
    check("t5_beat3_wlast", s_wlast, 1'b0);
    step();
    m_wlast = 2'b01;
    #1;
    check("t5_perr_single", protocol_err, 1'b0);
    check("t5_beat4_wlast", s_wlast, 1'b1);
    step();
    m_wvalid = 2'b00;
    m_wlast  = 2'b00;
    s_bvalid = 1'b1;
    s_bid    = 5'h09;
    #1;
    check("t5_m_bvalid", {busy, m_bvalid}, 3'b101);
    check("t5_m_bid", m_bid, 8'h09);
    step();
    s_bvalid  = 1'b0;
    m_awvalid = 2'b00;
    #1;
    check("t5_idle", {busy, m_bvalid}, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
